imm_gen_pipe: RTL

Pipelined, parametrised immediate generator for the decode stage. It accepts one instruction and its PC per cycle over a valid/ready handshake and decodes every RV32I/RV64I immediate format, including B-type and CSR zimm. It also computes the PC-relative target `pc + imm` and flags unknown encodings. The result is buffered in a 2-entry skid buffer so that decode backpressure never combinationally reaches fetch.

---
 rtl/imm_gen_pipe.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator with PC-relative target and a 2-entry skid buffer.
// Decoded results are registered so decode backpressure never reaches fetch combinationally.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    localparam bit IS64 = (XLEN == 64);
    localparam int EW   = 3 * XLEN + 4;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    logic [31:0]     raw_imm_d;
    logic [2:0]      fmt_d;
    logic            illegal_d;
    logic [XLEN-1:0] imm_d;
    logic [XLEN-1:0] target_d;
    logic [EW-1:0]   dec_d;

    // Every immediate fits a signed 32-bit value; widening to XLEN is one sign-extending cast.
    always_comb begin
        raw_imm_d = '0;
        fmt_d     = FMT_NONE;
        illegal_d = 1'b0;
        case (in_inst[6:0])
            7'b0110111, 7'b0010111: begin
                fmt_d     = FMT_U;
                raw_imm_d = {in_inst[31:12], 12'b0};
            end
            7'b1101111: begin
                fmt_d     = FMT_J;
                raw_imm_d = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                             in_inst[30:21], 1'b0};
            end
            7'b1100011: begin
                fmt_d     = FMT_B;
                raw_imm_d = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                             in_inst[11:8], 1'b0};
            end
            7'b0100011: begin
                fmt_d     = FMT_S;
                raw_imm_d = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111: begin
                fmt_d     = FMT_I;
                raw_imm_d = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            7'b1110011: begin
                if (in_inst[14]) begin
                    fmt_d     = FMT_Z;
                    raw_imm_d = {27'b0, in_inst[19:15]};
                end else begin
                    fmt_d     = FMT_I;
                    raw_imm_d = {{20{in_inst[31]}}, in_inst[31:20]};
                end
            end
            7'b0110011: fmt_d = FMT_NONE;
            7'b0011011: begin
                if (IS64) begin
                    fmt_d     = FMT_I;
                    raw_imm_d = {{20{in_inst[31]}}, in_inst[31:20]};
                end else begin
                    illegal_d = 1'b1;
                end
            end
            7'b0111011: illegal_d = !IS64;
            default:    illegal_d = 1'b1;
        endcase
        if (in_inst[1:0] != 2'b11) begin
            illegal_d = 1'b1;
            fmt_d     = FMT_NONE;
            raw_imm_d = '0;
        end
    end

    assign imm_d    = XLEN'(signed'(raw_imm_d));
    assign target_d = in_pc + imm_d;
    assign dec_d    = {imm_d, target_d, in_pc, fmt_d, illegal_d};

    state_t        state_q;
    logic          out_valid_q;
    logic          in_ready_q;
    logic [EW-1:0] out_q;
    logic [EW-1:0] skid_q;
    logic          acc;
    logic          pop;

    assign acc = in_valid & in_ready_q;
    assign pop = out_valid_q & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_q       <= '0;
            skid_q      <= '0;
        end else if (flush) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (acc) begin
                        out_q       <= dec_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (acc && !pop) begin
                        skid_q     <= dec_d;
                        in_ready_q <= 1'b0;
                        state_q    <= S_TWO;
                    end else if (acc && pop) begin
                        out_q <= dec_d;
                    end else if (pop) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (pop) begin
                        out_q      <= skid_q;
                        in_ready_q <= 1'b1;
                        state_q    <= S_ONE;
                    end
                end
                default: begin
                    state_q     <= S_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = out_q[EW-1 -: XLEN];
    assign out_target  = out_q[2*XLEN+3 -: XLEN];
    assign out_pc      = out_q[XLEN+3 -: XLEN];
    assign out_fmt     = out_q[3:1];
    assign out_illegal = out_q[0];

endmodule
